// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared scan state type and result-region address helpers
// Purpose : scan_state_t for the result scanner FSM; BASE/R derivation shared
//           with the CPU so both agree where the product matrix lives.
// Ports   : none (package)
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } scan_state_t;

    // Result matrix follows matrix1 (m x n) and matrix2 (n x n2) in data memory.
    function automatic int scan_base(input int m, input int n, input int n2);
        return m * n + n * n2;
    endfunction

    function automatic int scan_count(input int m, input int n2);
        return m * n2;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - registered rising-edge detector with synchronous reset
// Purpose : rise = 1 for the cycle where sig is high and was low the cycle before.
// Ports   : clk (clock), rst (sync active-high reset), sig (level input),
//           rise (single-cycle rising-edge indication)
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic sig_q;
    logic blocked;

    // sig_q is forced low by reset, so a level that is already high when reset
    // releases would look like an edge. blocked captures the level during reset
    // and suppresses rise until sig has been seen low at least once.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q   <= 1'b0;
            blocked <= sig;
        end else begin
            sig_q   <= sig;
            blocked <= blocked & sig;
        end
    end

    assign rise = sig & ~sig_q & ~blocked;

endmodule

// File: rtl/result_scanner.sv
// rtl/result_scanner.sv - reads the result matrix after program completion and checksums it
// Purpose : on a rising edge of done_i, reads words BASE..BASE+R-1 through the
//           data-memory second read port, sums them (wrapping) and counts them.
// Ports   : CLOCK_50 (clock), rst (sync active-high reset), done_i (program done),
//           mem_rd_en/mem_addr/mem_rdata (read port, data one cycle after strobe),
//           scan_done/checksum/word_cnt (results), LEDR (board LEDs),
//           min_val/max_val (signed extremes, only with SCAN_MINMAX_EN defined)
// Config  : SCAN_MINMAX_EN adds min_val/max_val tracking.
module result_scanner
    import riscv_pkg::*;
#(
    parameter int M      = 100,
    parameter int N      = 50,
    parameter int N2     = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  logic              done_i,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              scan_done,
    output logic [DATA_W-1:0] checksum,
    output logic [ADDR_W-1:0] word_cnt,
    output logic [9:0]        LEDR
`ifdef SCAN_MINMAX_EN
    ,
    output logic signed [DATA_W-1:0] min_val,
    output logic signed [DATA_W-1:0] max_val
`endif
);

    localparam int                BASE_I = scan_base(M, N, N2);
    localparam int                R_I    = scan_count(M, N2);
    localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_I);
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(BASE_I + R_I - 1);

    scan_state_t state;
    logic        rd_q;   // mem_rd_en delayed to line up with mem_rdata
    logic        start;

    edge_detect u_edge_detect (
        .clk  (CLOCK_50),
        .rst  (rst),
        .sig  (done_i),
        .rise (start)
    );

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state     <= IDLE;
            mem_rd_en <= 1'b0;
            mem_addr  <= BASE;
            rd_q      <= 1'b0;
            checksum  <= '0;
            word_cnt  <= '0;
            scan_done <= 1'b0;
        end else begin
            rd_q <= mem_rd_en;
            if (rd_q) begin
                checksum <= checksum + mem_rdata;
                word_cnt <= word_cnt + ADDR_W'(1);
            end
            case (state)
                // rd_q is always low here, so the clears never collide with accumulation.
                IDLE, DONE: begin
                    if (start) begin
                        state     <= SCAN;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= BASE;
                        checksum  <= '0;
                        word_cnt  <= '0;
                        scan_done <= 1'b0;
                    end
                end
                SCAN: begin
                    if (mem_addr == LAST) begin
                        state     <= DRAIN;
                        mem_rd_en <= 1'b0;
                        mem_addr  <= BASE;
                    end else begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end
                // Last word's data arrives this cycle and is added above.
                DRAIN: begin
                    state     <= DONE;
                    scan_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SCAN_MINMAX_EN
    // word_cnt is zero only for the first accumulated word of a scan.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            min_val <= '0;
            max_val <= '0;
        end else if (rd_q) begin
            if (word_cnt == '0) begin
                min_val <= $signed(mem_rdata);
                max_val <= $signed(mem_rdata);
            end else begin
                if ($signed(mem_rdata) < min_val) min_val <= $signed(mem_rdata);
                if ($signed(mem_rdata) > max_val) max_val <= $signed(mem_rdata);
            end
        end
    end
`endif

    assign LEDR = {scan_done, scan_done ? checksum[8:0] : 9'd0};

endmodule

// File: tb/tb_result_scanner.sv
// tb/tb_result_scanner.sv - directed self-checking bench for result_scanner
module tb_result_scanner;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 14;

    logic              CLOCK_50;
    logic              rst;
    logic              done_i;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              scan_done;
    logic [DATA_W-1:0] checksum;
    logic [ADDR_W-1:0] word_cnt;
    logic [9:0]        LEDR;
`ifdef SCAN_MINMAX_EN
    logic signed [DATA_W-1:0] min_val;
    logic signed [DATA_W-1:0] max_val;
`endif

    logic [DATA_W-1:0] mem [0:15];

    int tests_run    = 0;
    int tests_failed = 0;

    result_scanner #(
        .M      (2),
        .N      (2),
        .N2     (2),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .rst       (rst),
        .done_i    (done_i),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .scan_done (scan_done),
        .checksum  (checksum),
        .word_cnt  (word_cnt),
        .LEDR      (LEDR)
`ifdef SCAN_MINMAX_EN
        ,
        .min_val   (min_val),
        .max_val   (max_val)
`endif
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // Data memory second read port: data one cycle after the strobe.
    always @(posedge CLOCK_50) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr[3:0]];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d);
        mem[8]  = a;
        mem[9]  = b;
        mem[10] = c;
        mem[11] = d;
    endtask

    // Full scan from IDLE or DONE; optional done_i pulse during SCAN must be ignored.
    task automatic run_scan(input string tag, input logic [31:0] exp_sum, input bit pulse);
        logic [9:0] exp_led;
        exp_led = {1'b1, exp_sum[8:0]};
        done_i = 1'b0;
        tick();
        done_i = 1'b1;               // start cycle
        for (int k = 0; k < 4; k++) begin
            tick();
            check({tag, "_rd_en"}, 32'(mem_rd_en), 32'd1);
            check({tag, "_addr"}, 32'(mem_addr), 32'(8 + k));
            if (k == 0) check({tag, "_done_low"}, 32'(scan_done), 32'd0);
            if (pulse && k == 0) done_i = 1'b0;
            if (pulse && k == 1) done_i = 1'b1;
        end
        tick();                      // DRAIN
        check({tag, "_drain_rd_en"}, 32'(mem_rd_en), 32'd0);
        check({tag, "_drain_addr"}, 32'(mem_addr), 32'd8);
        check({tag, "_drain_done"}, 32'(scan_done), 32'd0);
        tick();                      // start + 6
        check({tag, "_scan_done"}, 32'(scan_done), 32'd1);
        check({tag, "_word_cnt"}, 32'(word_cnt), 32'd4);
        check({tag, "_checksum"}, checksum, exp_sum);
        check({tag, "_ledr"}, 32'(LEDR), 32'(exp_led));
        tick();                      // DONE holds
        check({tag, "_hold_done"}, 32'(scan_done), 32'd1);
        check({tag, "_hold_sum"}, checksum, exp_sum);
        check({tag, "_hold_rd_en"}, 32'(mem_rd_en), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        rst    = 1'b1;
        done_i = 1'b0;
        tick();
        tick();
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd8);
        check("rst_sum", checksum, 32'd0);
        check("rst_cnt", 32'(word_cnt), 32'd0);
        check("rst_done", 32'(scan_done), 32'd0);
        check("rst_ledr", 32'(LEDR), 32'd0);
        rst = 1'b0;
        tick();

        load(32'd1, 32'd2, 32'd3, 32'd4);
        run_scan("basic", 32'd10, 1'b0);

        load(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_scan("neg", 32'hFFFFFFFB, 1'b0);

        load(32'h7FFFFFFF, 32'd1, 32'd0, 32'd0);
        run_scan("wrap", 32'h80000000, 1'b0);

        // Restart from DONE with a pulse during SCAN; same data, same result.
        run_scan("rescan", 32'h80000000, 1'b1);

        // Reset on the second SCAN cycle with done_i held high.
        load(32'd1, 32'd2, 32'd3, 32'd4);
        done_i = 1'b0;
        tick();
        done_i = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("abort_rd_en", 32'(mem_rd_en), 32'd0);
        check("abort_sum", checksum, 32'd0);
        check("abort_cnt", 32'(word_cnt), 32'd0);
        check("abort_done", 32'(scan_done), 32'd0);
        check("abort_addr", 32'(mem_addr), 32'd8);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("no_rescan_rd_en", 32'(mem_rd_en), 32'd0);
            check("no_rescan_cnt", 32'(word_cnt), 32'd0);
        end
        run_scan("after_abort", 32'd10, 1'b0);

`ifdef SCAN_MINMAX_EN
        load(32'd5, 32'hFFFFFFF9, 32'd3, 32'd0);
        run_scan("minmax", 32'd1, 1'b0);
        check("min_val", min_val, 32'hFFFFFFF9);
        check("max_val", max_val, 32'd5);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
